// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the ALU and LSU write-back paths.
// Writes are registered: a grant at one edge drives rf_we/rf_addr/rf_wdata for the following cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [ADDR_W-1:0] lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers in any cycle where valid and ready are both high;
    // a requester holds valid, rd and data stable until it sees ready.

    typedef enum logic {PTR_ALU = 1'b0, PTR_LSU = 1'b1} ptr_e;

    ptr_e              ptr_q, ptr_d;
    logic              owed_q, owed_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic alu_zero, lsu_zero, alu_nz, lsu_nz;
    logic contend, same_rd;
    logic grant_alu, grant_lsu;

    assign alu_zero = alu_valid && (alu_rd == '0);
    assign lsu_zero = lsu_valid && (lsu_rd == '0);
    assign alu_nz   = alu_valid && (alu_rd != '0);
    assign lsu_nz   = lsu_valid && (lsu_rd != '0);
    assign contend  = alu_nz && lsu_nz;
    assign same_rd  = contend && (alu_rd == lsu_rd);

    // State register: priority pointer plus the "LSU lost a same-rd collision" flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= PTR_ALU;
            owed_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            owed_q  <= owed_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        ptr_d   = ptr_q;
        owed_d  = owed_q;
        we_d    = grant_alu || grant_lsu;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;

        // Only an ordinary distinct-rd contention moves the pointer.
        if (contend && !same_rd && !owed_q) begin
            ptr_d = (ptr_q == PTR_ALU) ? PTR_LSU : PTR_ALU;
        end

        if (same_rd && grant_alu) begin
            owed_d = 1'b1;
        end else if (grant_lsu) begin
            owed_d = 1'b0;
        end

        if (grant_alu) begin
            addr_d  = alu_rd;
            wdata_d = alu_data;
        end else if (grant_lsu) begin
            addr_d  = lsu_rd;
            wdata_d = lsu_data;
        end

        if (contend && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Output logic: grants for nonzero-rd requests; rd = 0 requests are accepted unconditionally.
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (contend) begin
            if (owed_q) begin
                grant_lsu = 1'b1;
            end else if (same_rd) begin
                grant_alu = 1'b1;
            end else if (ptr_q == PTR_ALU) begin
                grant_alu = 1'b1;
            end else begin
                grant_lsu = 1'b1;
            end
        end else begin
            grant_alu = alu_nz;
            grant_lsu = lsu_nz;
        end
        alu_ready = rst && (grant_alu || alu_zero);
        lsu_ready = rst && (grant_lsu || lsu_zero);
    end

    assign rf_we        = we_q;
    assign rf_addr      = addr_q;
    assign rf_wdata     = wdata_q;
    assign conflict_cnt = cnt_q;
    assign dbg_state    = {owed_q, ptr_q};

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, register data width.
REQ-002 Parameter: ADDR_W, default 5, register index width (32 registers).
REQ-003 Parameter: CNT_W, default 16, conflict counter width.
REQ-004 The block SHALL use one clock, clk; reset rst SHALL be asynchronous and active-low.
REQ-005 Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  load write-back request.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- lsu_ready  out  1  load request accepted this cycle.
- rf_we  out  1  register-file write enable.
- rf_addr  out  ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- conflict_cnt  out  CNT_W  count of contended cycles.

Function
REQ-006 Role: share the register file's single write port between the ALU and LSU write-back paths.
REQ-007 Handshake: a transfer occurs when valid and ready are both high in the same cycle.
- Once valid is raised, the requester SHALL hold valid, rd and data stable until accepted.
REQ-008 alu_ready and lsu_ready SHALL be combinational from the current requests and the priority pointer.
- At most one ready SHALL be high per cycle, except as stated in REQ-010.
REQ-009 A request with rd = 0 SHALL be accepted immediately and SHALL NOT assert rf_we.
- It SHALL NOT consume the write slot.
- It SHALL NOT affect the pointer or the counter.
REQ-010 If both requests target rd = 0, both readies SHALL be high in the same cycle.
REQ-011 If exactly one request is valid with rd ≠ 0, it SHALL be granted that cycle.
- The pointer SHALL be unchanged.
REQ-012 If both requests are valid with rd ≠ 0 (contention), the side indicated by the priority pointer SHALL be granted.
- The pointer SHALL then toggle to the other side.
- conflict_cnt SHALL increment.
REQ-013 Same-rd contention (alu_rd = lsu_rd ≠ 0) SHALL override the pointer.
- ALU is granted first and LSU in the following cycle, so the LSU value is the final register content.
- The pointer SHALL remain unchanged.
- conflict_cnt SHALL increment once per contended cycle.
REQ-014 The losing requester SHALL see ready low and SHALL keep requesting.
- No requester SHALL be denied more than one consecutive contended cycle.
REQ-015 Write latency: a grant at edge N SHALL present rf_we=1, rf_addr=rd and rf_wdata=data, all registered, for exactly the cycle after edge N.
- In cycles with no nonzero-rd grant, rf_we SHALL be 0; rf_addr and rf_wdata SHALL hold their last values.
REQ-016 The state machine SHALL have states PTR_ALU and PTR_LSU (the priority pointer).
- Transitions occur only per REQ-012.
REQ-017 conflict_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-018 Sustained throughput SHALL be one register write per cycle.

Reset
REQ-019 While rst is low, the block SHALL force: rf_we=0, rf_addr=0, rf_wdata=0, conflict_cnt=0, pointer=PTR_ALU, alu_ready=0, lsu_ready=0.
REQ-020 A reset asserted mid-operation SHALL discard any pending or registered write.
- No rf_we pulse SHALL appear after rst falls.
- After rst rises, arbitration SHALL restart from PTR_ALU.

Verification
REQ-021 Single ALU request: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF; conflict_cnt=0.
REQ-022 Contention, distinct rd: ALU rd=3, LSU rd=7, both held -> cycle 0 ALU granted; cycle 1 LSU granted; writes to 3 then 7 on consecutive cycles; conflict_cnt=1; pointer=PTR_LSU.
REQ-023 Same-rd collision: both rd=9, ALU data=0x1, LSU data=0x2 -> rf writes 0x1 then 0x2 to reg 9; pointer unchanged; conflict_cnt=1.
REQ-024 x0 filtering: LSU rd=0 and ALU rd=4 both valid -> both readies high same cycle; only write is reg 4; conflict_cnt=0.
REQ-025 Saturation and reset: CNT_W=4 with 20 contended cycles -> conflict_cnt=0xF.
- Then rst low for 1 cycle during a grant -> all outputs 0, no rf_we pulse, pointer=PTR_ALU after release.
